// File: rtl/lsu_pkg.sv
// Shared types, RV32I funct3 codes and request-decode helpers for the load/store unit.
// The misalignment helper is only referenced when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic lsu_bad_kind(input logic ld, input logic st, input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        if (ld == st) begin
            bad = 1'b1;
        end else if (ld) begin
            case (f3)
                LB, LH, LW, LBU, LHU: bad = 1'b0;
                default:              bad = 1'b1;
            endcase
        end else begin
            case (f3)
                SB, SH, SW: bad = 1'b0;
                default:    bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Size comes from funct3[1:0] for both loads and stores.
    function automatic logic [1:0] lsu_align_lo(input logic [2:0] f3, input logic [1:0] lo);
        logic [1:0] res;
        case (f3[1:0])
            2'b01:   res = {lo[1], 1'b0};
            2'b10:   res = 2'b00;
            default: res = lo;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load lane extraction with sign/zero extension,
// and byte/halfword merge of store data into the read-back RAM word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted_s;
    logic [31:0] mask_s;

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted_s = rdata >> {lane, 3'b000};
        case (funct3)
            LB:      load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LH:      load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LW:      load_data = shifted_s;
            LBU:     load_data = {24'h000000, shifted_s[7:0]};
            LHU:     load_data = {16'h0000, shifted_s[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store path: replace only the masked lane of the current RAM word.
    always_comb begin
        case (funct3)
            SB:      mask_s = 32'h0000_00FF << {lane, 3'b000};
            SH:      mask_s = 32'h0000_FFFF << {lane, 3'b000};
            default: mask_s = 32'h0000_0000;
        endcase
        merge_data = (rdata & ~mask_s) | (({16'h0000, wdata} << {lane, 3'b000}) & mask_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a single-port word RAM with registered read data.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic              mem_store,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t         state_r;
    logic [ADDR_W+1:0]  addr_r;
    logic [2:0]         funct3_r;
    logic               is_store_r;
    logic [31:0]        wdata_r;
    logic [31:0]        rdata_r;
    logic               rsp_err_r;
    logic [31:0]        mem_wdata_r;

    logic               accept_s;
    logic               invalid_s;
    logic [31:0]        load_data_s;
    logic [31:0]        merge_data_s;
    logic               unused_s;

    assign accept_s = req_valid & req_ready;
    assign unused_s = ^req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign invalid_s = lsu_bad_kind(req_load, req_store, req_funct3)
                     | lsu_misaligned(req_funct3, req_addr[1:0]);
`else
    assign invalid_s = lsu_bad_kind(req_load, req_store, req_funct3);
`endif

    lsu_align u_align (
        .funct3     (funct3_r),
        .lane       (addr_r[1:0]),
        .rdata      (mem_rdata),
        .wdata      (wdata_r[15:0]),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

    // Transaction FSM and all registered response/write-data state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            funct3_r    <= 3'b000;
            is_store_r  <= 1'b0;
            wdata_r     <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r     <= {req_addr[ADDR_W+1:2], lsu_align_lo(req_funct3, req_addr[1:0])};
                        funct3_r   <= req_funct3;
                        is_store_r <= req_store;
                        wdata_r    <= req_wdata;
                        if (invalid_s) begin
                            rsp_err_r <= 1'b1;
                            rdata_r   <= 32'h0000_0000;
                            state_r   <= RESP;
                        end else if (req_store && (req_funct3 == SW)) begin
                            mem_wdata_r <= req_wdata;
                            state_r     <= WR;
                        end else begin
                            state_r <= RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    state_r <= DATA;
                end
                DATA: begin
                    if (is_store_r) begin
                        mem_wdata_r <= merge_data_s;
                        state_r     <= WR;
                    end else begin
                        rdata_r   <= load_data_s;
                        rsp_err_r <= 1'b0;
                        state_r   <= RESP;
                    end
                end
                WR: begin
                    rdata_r   <= 32'h0000_0000;
                    rsp_err_r <= 1'b0;
                    state_r   <= RESP;
                end
                RESP: begin
                    rsp_err_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by rst so an abandoned transaction never reaches the RAM.
    assign req_ready = (state_r == IDLE);
    assign mem_load  = (state_r == RD)   & ~rst;
    assign mem_store = (state_r == WR)   & ~rst;
    assign rsp_valid = (state_r == RESP) & ~rst;
    assign mem_addr  = addr_r[ADDR_W+1:2];
    assign mem_wdata = mem_wdata_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a response scoreboard,
// plus hand-written reset-abort sequence. Expectations follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    localparam int ADDR_W = 5;
    localparam int NV     = 17;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_load;
    logic              mem_store;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench RAM: registered read, write on strobe, direct preload of word 4.
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    logic        pre_we;
    logic [31:0] pre_val;
    always @(posedge clk) begin
        if (pre_we) ram[4] <= pre_val;
        else if (mem_store) ram[mem_addr] <= mem_wdata;
        if (mem_load) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        pre_en;
        logic [31:0] pre_val;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t  vecs [NV];
    exp_t  exp_q [$];
    int    n_checks;
    int    n_fail;

    logic        tr_ld  [16];
    logic        tr_st  [16];
    logic [4:0]  tr_addr[16];
    logic [31:0] tr_wd  [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pe, input logic [31:0] pv, input logic ld, input logic st,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee, input int el);
        vec_t v;
        v.pre_en = pe; v.pre_val = pv; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    task automatic preload(input logic [31:0] val);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_val = val;
        @(posedge clk);
        #1;
        pre_we  = 1'b0;
    endtask

    // Issue one request, push its expectation, then wait (bounded) for the response.
    task automatic run_vec(input int i);
        vec_t v;
        exp_t e;
        exp_t got;
        int   n_ld;
        int   n_st;
        bit   seen;
        v = vecs[i];
        if (v.pre_en) preload(v.pre_val);
        @(negedge clk);
        check($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_load   = v.ld;
        req_store  = v.st;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_ld = 0;
        n_st = 0;
        seen = 1'b0;
        for (int c = 1; c < 12 && !seen; c++) begin
            @(negedge clk);
            tr_ld[c] = mem_load; tr_st[c] = mem_store; tr_addr[c] = mem_addr; tr_wd[c] = mem_wdata;
            if (mem_load) n_ld++;
            if (mem_store) n_st++;
            if (mem_load && mem_store) check($sformatf("v%0d_strobe_overlap", i), 32'd1, 32'd0);
            if (rsp_valid) begin
                seen = 1'b1;
                got = exp_q.pop_front();
                check($sformatf("v%0d_latency", i), c, got.lat);
                check($sformatf("v%0d_rdata", i), rsp_rdata, got.rdata);
                check($sformatf("v%0d_err", i), {31'd0, rsp_err}, {31'd0, got.err});
            end
        end
        if (!seen) begin
            check($sformatf("v%0d_timeout", i), 32'd0, 32'd1);
            exp_q.delete();
        end
        check($sformatf("v%0d_nload", i), n_ld,
              (!v.exp_err && (v.ld || v.f3 != 3'b010)) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_nstore", i), n_st, (!v.exp_err && v.st) ? 32'd1 : 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_pulse_end", i), {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        pre_we    = 1'b0;
        pre_val   = 32'h0;
        for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = 32'h0;

        vecs[0]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        vecs[1]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        vecs[2]  = mk(1'b1, 32'h11223344, 1'b0, 1'b1, 3'b000, 32'h12, 32'h123456AA, 32'h0, 1'b0, 4);
        vecs[3]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h11AA3344, 1'b0, 3);
        vecs[4]  = mk(1'b1, 32'h80FF7F01, 1'b1, 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 3);
        vecs[5]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b100, 32'h12, 32'h0, 32'h000000FF, 1'b0, 3);
        vecs[6]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 3);
        vecs[7]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 1'b0, 3);
        vecs[8]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 3'b001, 32'h12, 32'h9999BEEF, 32'h0, 1'b0, 4);
        vecs[9]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF7F01, 1'b0, 3);
        vecs[10] = mk(1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        vecs[11] = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        vecs[12] = mk(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        vecs[13] = mk(1'b0, 32'h0, 1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        vecs[14] = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h90, 32'h0, 32'hBEEF7F01, 1'b0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[15] = mk(1'b1, 32'h11223344, 1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1);
`else
        vecs[15] = mk(1'b1, 32'h11223344, 1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 32'h00003344, 1'b0, 3);
`endif
        vecs[16] = mk(1'b0, 32'h0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'h00000011, 1'b0, 3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_strobes", {30'd0, mem_load, mem_store}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_vec(i);
            if (i == 0) begin
                check("sw_c1_store", {31'd0, tr_st[1]}, 32'd1);
                check("sw_c1_addr", {27'd0, tr_addr[1]}, 32'd4);
                check("sw_c1_wdata", tr_wd[1], 32'hDEADBEEF);
            end
            if (i == 2) begin
                check("sb_c1_load", {31'd0, tr_ld[1]}, 32'd1);
                check("sb_c2_idle", {30'd0, tr_ld[2], tr_st[2]}, 32'd0);
                check("sb_c3_store", {31'd0, tr_st[3]}, 32'd1);
                check("sb_c3_wdata", tr_wd[3], 32'h11AA3344);
                check("sb_ram", ram[4], 32'h11AA3344);
            end
        end

        // Reset during the DATA cycle of an SB abandons the write.
        preload(32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
        req_funct3 = 3'b000; req_addr = 32'h12; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_c1_load", {31'd0, mem_load}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rst_strobes", {29'd0, mem_load, mem_store, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_mem_wdata", mem_wdata, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("abort_no_store%0d", c), {30'd0, mem_store, rsp_valid}, 32'd0);
        end
        check("abort_ram", ram[4], 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, word-address width of the data RAM (2^ADDR_W 32-bit words).
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result, extended.
- rsp_err  out  1  request rejected; no memory write occurred.
- mem_addr  out  ADDR_W  RAM word address.
- mem_load  out  1  RAM read strobe.
- mem_store  out  1  RAM write strobe.
- mem_wdata  out  32  RAM write word.
- mem_rdata  in  32  RAM read word, registered, valid the cycle after the mem_load cycle.

Function
REQ-003 SHALL use FSM states IDLE, RD, DATA, WR, RESP.
REQ-004 SHALL assert req_ready only in IDLE; acceptance is req_valid & req_ready; addr, funct3, wdata and kind SHALL be latched on acceptance.
REQ-005 SHALL transition IDLE->RD for a load or SB/SH, IDLE->WR for SW, and IDLE->RESP with rsp_err=1 for any invalid request.
REQ-006 SHALL treat as invalid: req_load==req_store; load funct3 outside {000,001,010,100,101}; store funct3 outside {000,001,010}.
REQ-007 SHALL drive mem_addr = latched addr[ADDR_W+1:2]; higher address bits are ignored (wrap-around).
REQ-008 SHALL assert mem_load only in RD and mem_store only in WR; the two strobes SHALL never be high together.
REQ-009 SHALL, in DATA for a load, register the selected lane (addr[1:0]) into rsp_rdata, sign-extended for LB/LH and zero-extended for LBU/LHU, then go to RESP.
REQ-010 SHALL, in DATA for SB/SH, merge the low byte/halfword of wdata into mem_rdata at the lane given by addr[1:0], register the result as mem_wdata, then go to WR.
REQ-011 SHALL, for SW, drive mem_wdata = wdata in WR; WR always goes to RESP.
REQ-012 SHALL pulse rsp_valid for exactly one cycle in RESP, then return to IDLE.
REQ-013 SHALL complete in fixed latencies after the acceptance edge: load 3 cycles, SW 2, SB/SH 4, error 1.
REQ-014 SHALL hold rsp_rdata until the next load completes; rsp_rdata is 0 on stores and errors.

Reset
REQ-015 SHALL, while rst=1 at a rising edge, enter IDLE and clear rsp_rdata, rsp_err and mem_wdata.
REQ-016 SHALL force mem_load, mem_store and rsp_valid to 0 combinationally whenever rst=1, so an in-flight transaction is abandoned with no write issued.

Configuration
REQ-017 SHALL honour macro LSU_MISALIGN_TRAP_EN. When defined: a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 is invalid under REQ-005. When undefined: the low address bits are forced to alignment (halfword addr[0]=0, word addr[1:0]=0) and the access proceeds.

Structure
REQ-018 SHALL place the state enum and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) in package lsu_pkg.
REQ-019 SHALL implement lane extraction, extension and store merge in combinational sub-module lsu_align, instantiated once.

Verification
REQ-020 SHALL cover: store SW 0xDEADBEEF at address 0x10, then LW 0x10 -> mem_store in cycle 1 with mem_addr=4; load rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after acceptance.
REQ-021 SHALL cover: preload word 4 = 0x11223344, then SB 0xAA at address 0x12 -> RD, DATA, WR sequence with mem_wdata=0x11AA3344, rsp_valid 4 cycles after acceptance.
REQ-022 SHALL cover: word 4 = 0x80FF7F01 -> LB 0x12 returns 0xFFFFFFFF, LBU 0x12 returns 0x000000FF, LH 0x12 returns 0xFFFF80FF, LHU 0x10 returns 0x00007F01.
REQ-023 SHALL cover: request with req_load=req_store=1, and LW with funct3=011 -> rsp_valid with rsp_err=1 one cycle after acceptance, with no mem_load or mem_store.
REQ-024 SHALL cover: LH at 0x11 -> with LSU_MISALIGN_TRAP_EN, rsp_err=1; without it, the access reads lanes 1:0 of word 4.
REQ-025 SHALL cover: rst asserted during the DATA cycle of an SB -> mem_store is never asserted, the next cycle is IDLE with req_ready=1, and RAM contents are unchanged.
